// File: rtl/fir_tap_mac_sequencer.sv
// Eight-tap FIR MAC sequencer: one shared 8x8 multiply per cycle over a latched tap window.
// Optional macro SAT16_OUT_EN clamps y to 16 bits and adds the sat_flag output.
module fir_tap_lane #(
  parameter int         DW  = 8,
  parameter int         CW  = 8,
  parameter logic [2:0] IDX = 3'd0
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          accept,
  input  logic [DW-1:0] a,
  input  logic          coef_wr,
  input  logic [2:0]    coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic [DW-1:0] tap,
  output logic [CW-1:0] coef
);
  logic [CW-1:0] shadow;

  // Active coef takes the pre-edge shadow, so a write on the accept edge lands next time.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tap    <= '0;
      shadow <= '0;
      coef   <= '0;
    end else begin
      if (accept) begin
        tap  <= a;
        coef <= shadow;
      end
      if (coef_wr && coef_addr == IDX) shadow <= coef_data;
    end
  end
endmodule

module fir_tap_mac_sequencer #(
  parameter  int DW = 8,
  parameter  int CW = 8,
  localparam int YW = DW + CW + 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          enable,
  input  logic          sample_valid,
  input  logic [DW-1:0] A0,
  input  logic [DW-1:0] A1,
  input  logic [DW-1:0] A2,
  input  logic [DW-1:0] A3,
  input  logic [DW-1:0] A4,
  input  logic [DW-1:0] A5,
  input  logic [DW-1:0] A6,
  input  logic [DW-1:0] A7,
  input  logic          coef_wr,
  input  logic [2:0]    coef_addr,
  input  logic [CW-1:0] coef_data,
  input  logic          overrun_clr,
  output logic [YW-1:0] y,
  output logic          y_valid,
  output logic          busy,
  output logic          overrun
`ifdef SAT16_OUT_EN
  ,
  output logic          sat_flag
`endif
);
  localparam int         NUM_LANES = 8;
  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] RUN       = 1'b1;

  logic [0:0]                    state;
  logic [2:0]                    idx;
  logic [YW-1:0]                 acc;
  logic [NUM_LANES-1:0][DW-1:0]  a_vec;
  logic [NUM_LANES-1:0][DW-1:0]  taps;
  logic [NUM_LANES-1:0][CW-1:0]  coefs;
  logic [DW+CW-1:0]              prod;
  logic [YW-1:0]                 sum;
  logic                          accept;

  assign a_vec  = {A7, A6, A5, A4, A3, A2, A1, A0};
  assign accept = (state == IDLE) && enable && sample_valid;
  assign prod   = taps[idx] * coefs[idx];
  assign sum    = acc + YW'(prod);
  assign busy   = (state == RUN);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    fir_tap_lane #(.DW(DW), .CW(CW), .IDX(3'(k))) u_lane (
      .clk       (clk),
      .resetn    (resetn),
      .accept    (accept),
      .a         (a_vec[k]),
      .coef_wr   (coef_wr),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .tap       (taps[k]),
      .coef      (coefs[k])
    );
  end

`ifdef SAT16_OUT_EN
  localparam logic [YW-1:0] SAT_MAX = YW'(17'h0FFFF);
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      idx     <= '0;
      acc     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
`ifdef SAT16_OUT_EN
      sat_flag <= 1'b0;
`endif
    end else begin
      y_valid <= 1'b0;
`ifdef SAT16_OUT_EN
      sat_flag <= 1'b0;
`endif
      if (state == IDLE) begin
        if (accept) begin
          acc   <= '0;
          idx   <= '0;
          state <= RUN;
        end
      end else if (enable) begin
        if (idx == 3'd7) begin
`ifdef SAT16_OUT_EN
          y        <= (sum > SAT_MAX) ? SAT_MAX : sum;
          sat_flag <= (sum > SAT_MAX);
`else
          y        <= sum;
`endif
          y_valid <= 1'b1;
          state   <= IDLE;
          idx     <= '0;
        end else begin
          acc <= sum;
          idx <= idx + 3'd1;
        end
      end
      // A strobe while busy (including the completing edge) is dropped; set beats clear.
      if (sample_valid && state == RUN) overrun <= 1'b1;
      else if (overrun_clr)             overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fir_tap_mac_sequencer.sv
// Directed bench for fir_tap_mac_sequencer with an abstract per-window model checked every cycle.
module tb_fir_tap_mac_sequencer;
  localparam int YW = 19;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b1;
  logic          sample_valid = 1'b0;
  logic [7:0]    a_in [8];
  logic          coef_wr = 1'b0;
  logic [2:0]    coef_addr = '0;
  logic [7:0]    coef_data = '0;
  logic          overrun_clr = 1'b0;
  logic [YW-1:0] y;
  logic          y_valid, busy, overrun;
`ifdef SAT16_OUT_EN
  logic          sat_flag;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fir_tap_mac_sequencer dut (
    .clk(clk), .resetn(resetn), .enable(enable), .sample_valid(sample_valid),
    .A0(a_in[0]), .A1(a_in[1]), .A2(a_in[2]), .A3(a_in[3]),
    .A4(a_in[4]), .A5(a_in[5]), .A6(a_in[6]), .A7(a_in[7]),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .overrun_clr(overrun_clr), .y(y), .y_valid(y_valid), .busy(busy), .overrun(overrun)
`ifdef SAT16_OUT_EN
    , .sat_flag(sat_flag)
`endif
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: the whole dot product is taken at accept; completion is counted in enabled edges.
  longint m_y, m_pend;
  int     m_left;
  bit     m_busy, m_yv, m_ovr, m_sat;
  int     m_shadow [8];

  always @(posedge clk) begin
    bit ovr_set;
    if (!resetn) begin
      m_y = 0; m_busy = 0; m_yv = 0; m_ovr = 0; m_sat = 0; m_left = 0;
      for (int k = 0; k < 8; k++) m_shadow[k] = 0;
    end else begin
      m_yv = 0; m_sat = 0;
      ovr_set = sample_valid && m_busy;
      if (!m_busy) begin
        if (enable && sample_valid) begin
          m_pend = 0;
          for (int k = 0; k < 8; k++) m_pend += longint'(a_in[k]) * m_shadow[k];
          m_busy = 1; m_left = 8;
        end
      end else if (enable) begin
        m_left--;
        if (m_left == 0) begin
`ifdef SAT16_OUT_EN
          m_sat = (m_pend > 65535);
          m_y   = m_sat ? 65535 : m_pend;
`else
          m_y   = m_pend;
`endif
          m_yv = 1; m_busy = 0;
        end
      end
      if (ovr_set) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
      if (coef_wr) m_shadow[coef_addr] = coef_data;
    end
    #1;
    chk("y", y, m_y);
    chk("y_valid", y_valid, m_yv);
    chk("busy", busy, m_busy);
    chk("overrun", overrun, m_ovr);
`ifdef SAT16_OUT_EN
    chk("sat_flag", sat_flag, m_sat);
`endif
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic set_taps(input int v);
    for (int k = 0; k < 8; k++) a_in[k] = 8'(v);
  endtask

  task automatic wcoef(input int k, input int d);
    coef_wr = 1'b1; coef_addr = 3'(k); coef_data = 8'(d);
    step();
    coef_wr = 1'b0;
  endtask

  task automatic accept();
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  // Counts edges from accept to y_valid; optionally drops enable for dis_len edges after dis_at.
  task automatic wait_done(input string nm, input int exp_lat, input longint exp_y,
                           input int exp_sat, input int dis_at, input int dis_len);
    int n = 0;
    int bc = int'(busy);
    bit got = 0;
    while (n < 60 && !got) begin
      if (n == dis_at) enable = 1'b0;
      if (n == dis_at + dis_len) enable = 1'b1;
      step();
      n++;
      if (y_valid) got = 1;
      else bc += int'(busy);
    end
    enable = 1'b1;
    chk({nm, " done"}, got, 1);
    chk({nm, " latency"}, n, exp_lat);
    chk({nm, " busy cycles"}, bc, exp_lat);
    chk({nm, " y"}, y, exp_y);
`ifdef SAT16_OUT_EN
    chk({nm, " sat"}, sat_flag, exp_sat);
`else
    chk({nm, " sat n/a"}, 0, exp_sat & 0);
`endif
    step();
    chk({nm, " single pulse"}, y_valid, 0);
  endtask

`ifdef SAT16_OUT_EN
  localparam longint Y_MAX = 65535;
  localparam int     S_MAX = 1;
`else
  localparam longint Y_MAX = 520200;
  localparam int     S_MAX = 0;
`endif

  initial begin
    set_taps(0);
    step(); step();
    resetn = 1'b1;
    chk("reset y", y, 0);
    chk("reset busy", busy, 0);
    chk("reset overrun", overrun, 0);
    chk("reset y_valid", y_valid, 0);

    // zero coefficients
    set_taps(10);
    accept();
    wait_done("t1", 8, 0, 0, -1, 0);

    // coefs 1..8, taps 10
    for (int k = 0; k < 8; k++) wcoef(k, k + 1);
    accept();
    wait_done("t2", 8, 360, 0, -1, 0);

    // worst-case magnitude
    for (int k = 0; k < 8; k++) wcoef(k, 255);
    set_taps(255);
    accept();
    wait_done("t3", 8, Y_MAX, S_MAX, -1, 0);

    // overrun mid-run, then on the completing edge
    for (int k = 0; k < 8; k++) wcoef(k, k + 1);
    set_taps(10);
    accept();
    step(); step();
    sample_valid = 1'b1; step(); sample_valid = 1'b0;
    chk("t4 overrun set", overrun, 1);
    wait_done("t4a", 5, 360, 0, -1, 0);
    overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
    chk("t4 overrun clr", overrun, 0);
    accept();
    repeat (7) step();
    sample_valid = 1'b1; step(); sample_valid = 1'b0;
    chk("t4 completing y_valid", y_valid, 1);
    chk("t4 completing overrun", overrun, 1);
    step();
    chk("t4 strobe dropped", busy, 0);
    accept();
    step();
    sample_valid = 1'b1; overrun_clr = 1'b1; step();
    sample_valid = 1'b0; overrun_clr = 1'b0;
    chk("t4 set beats clr", overrun, 1);
    wait_done("t4b", 6, 360, 0, -1, 0);
    overrun_clr = 1'b1; step(); overrun_clr = 1'b0;

    // enable low in IDLE ignores the strobe
    enable = 1'b0; sample_valid = 1'b1; step();
    sample_valid = 1'b0; enable = 1'b1;
    chk("idle disabled busy", busy, 0);
    chk("idle disabled overrun", overrun, 0);

    // coef write on accept edge + 5-cycle stall
    coef_wr = 1'b1; coef_addr = 3'd0; coef_data = 8'd99;
    accept();
    coef_wr = 1'b0;
    wait_done("t5a", 13, 360, 0, 3, 5);
    accept();
    wait_done("t5b", 8, 1340, 0, -1, 0);

    // reset mid-run
    accept();
    step(); step(); step();
    resetn = 1'b0; step(); resetn = 1'b1;
    chk("t6 busy", busy, 0);
    chk("t6 y", y, 0);
    chk("t6 overrun", overrun, 0);
    repeat (8) step();
    chk("t6 no y_valid", y_valid, 0);
    accept();
    wait_done("t6", 8, 0, 0, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fir_tap_mac_sequencer.md
Name: fir_tap_mac_sequencer

Overview:
Sequences one shared 8x8 unsigned multiply-accumulate across the eight FIFO tap outputs (A0..A7) to produce one FIR output per accepted sample window. It sits between the tap FIFO system and the output stage, in the fast clock domain, and computes one tap per cycle. It owns the coefficient bank: a shadow bank written by the host and an active bank that is latched at the start of each computation.

Parameters:
DW, 8, sample/tap width (unsigned)
CW, 8, coefficient width (unsigned)
YW, DW+CW+3, output width; derived, do not override

Ports:
clk  in  1  single clock; all logic on posedge
resetn  in  1  synchronous active-low reset
enable  in  1  global run enable; low = hold
sample_valid  in  1  one-cycle strobe: A7..A0 hold a new window
A0..A7  in  DW each  tap values; Ak is multiplied by coefficient k
coef_wr  in  1  shadow coefficient write strobe
coef_addr  in  3  coefficient index 0..7
coef_data  in  CW  coefficient value
overrun_clr  in  1  clears sticky overrun
y  out  YW  last completed result
y_valid  out  1  one-cycle pulse when y updates
busy  out  1  high while state == RUN
overrun  out  1  sticky: sample_valid dropped

Behaviour:
- Reset (resetn low at posedge): state IDLE, idx 0, acc 0, y 0, y_valid 0, busy 0, overrun 0, all shadow and active coefficients 0. Reset overrides every other input, including mid-RUN; an in-flight result is discarded and no y_valid is produced.
- States: IDLE, RUN.
- IDLE: when enable and sample_valid are both high at an edge:
  - snapshot A0..A7 into internal tap registers;
  - copy the shadow bank (its pre-edge contents) into the active bank;
  - clear acc, set idx to 0, go to RUN.
  - When enable is low, sample_valid is ignored and overrun is not set.
- RUN, each edge with enable high:
  - acc <= acc + tap[idx]*coef_act[idx], then idx++.
  - At idx==7: y <= acc + tap[7]*coef_act[7], y_valid <= 1 for exactly one cycle, state <= IDLE, idx <= 0.
  - Latency: y_valid is high in the 8th cycle after the accept edge. Minimum spacing between accepted samples is 9 cycles.
- RUN with enable low: idx, acc and the snapshot hold. Completion slips by the number of enable-low cycles.
- Arithmetic: unsigned and full precision. Worst case is 8*(2^DW-1)*(2^CW-1), which fits in YW bits with no wrap.
- coef_wr: accepted in any state; writes shadow[coef_addr] <= coef_data. It never affects a computation already in RUN. A write on the same edge as an accept is NOT used by that computation.
- Overrun:
  - sample_valid high in RUN (enable high or low) sets overrun; the request is dropped.
  - This includes the completing edge, idx==7.
  - overrun_clr clears it. If set and clear happen on the same edge, set wins.
- y holds its value between completions. busy == (state == RUN).

Optional Feature:
SAT16_OUT_EN
- Defined: the completion edge loads min(full_sum, 65535) into y; y[YW-1:16] is always 0. An extra output sat_flag pulses together with y_valid when clamping occurred.
- Undefined: y carries the full YW-bit sum; sat_flag does not exist.

Test Plan:
1. Reset, then sample_valid with A0..A7 = 10 and all coefficients 0 -> busy is high for 8 cycles; y_valid is high 8 cycles after accept; y = 0.
2. Write coef k = k+1 (1..8), A0..A7 = 10, then sample_valid -> y = 360 at +8 cycles; exactly one y_valid pulse.
3. All taps 255, all coefficients 255 -> y = 520200. With SAT16_OUT_EN: y = 65535 and sat_flag = 1.
4. Second sample_valid 3 cycles after accept -> dropped; overrun = 1; first y (360) is unaffected. overrun_clr -> overrun = 0. Strobe on the completing edge -> also dropped.
5. enable low for 5 cycles mid-RUN -> y_valid appears at +13 cycles with an unchanged y. coef write to addr 0 = 99 on the accept edge -> the current result uses the old value; the next computation uses 99.
6. resetn low at cycle 4 of RUN -> busy = 0, y = 0, no y_valid, coefficients = 0. A following sample_valid then yields y = 0.
